// File: rtl/cmos_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : cmos_frame_packer
// Purpose  : CMOS sensor capture front end. Skips the first frames after
//            sensor configuration, packs byte pairs into RGB565 words for
//            the DDR3 write port and flags short/long lines and frames.
// Revision : 1.0  initial release
// ============================================================================
module cmos_frame_packer #(
  parameter int WAIT_FRAME = 10,   // vsync rising edges to skip (1..15)
  parameter int H_PIXEL    = 640,  // expected 16-bit words per line
  parameter int V_PIXEL    = 480   // expected lines per frame
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        sys_init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wr_load,
  output logic        datain_valid,
  output logic [15:0] datain,
  output logic        frame_val,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [3:0]  c_wait     = 4'(WAIT_FRAME);
  localparam logic [3:0]  c_wait_m1  = 4'(WAIT_FRAME - 1);
  localparam logic [11:0] c_h_pixel  = 12'(H_PIXEL);
  localparam logic [10:0] c_v_pixel  = 11'(V_PIXEL);
  localparam logic [11:0] c_word_max = 12'hFFF;
  localparam logic [10:0] c_line_max = 11'h7FF;

  // Input sampling stages
  logic        r_vsync_d0;
  logic        r_vsync_d1;
  logic        r_href_d0;
  logic        r_href_d1;
  logic [7:0]  r_data_d0;

  // Frame wait logic
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_next;

  // Byte packing pipeline
  logic        r_toggle;
  logic [7:0]  r_hi_byte;
  logic [15:0] r_pend_word;
  logic        r_pend_vld;

  // Line / frame geometry counters
  logic [11:0] r_word_cnt;
  logic [11:0] w_word_total;
  logic [10:0] r_line_cnt;

  logic        w_pos_vsync;
  logic        w_neg_href;
  logic        w_word_strobe;

  assign w_pos_vsync = r_vsync_d0 & ~r_vsync_d1;
  assign w_neg_href  = ~r_href_d0 & r_href_d1;

  // A word leaves the pipeline only while capture is enabled; dropping
  // sys_init_done kills the strobe on the very next edge.
  assign w_word_strobe = r_pend_vld & frame_val & sys_init_done;

  // Register every sensor input once, plus a second stage for edge detection
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_vsync_d0 <= 1'b0;
      r_vsync_d1 <= 1'b0;
      r_href_d0  <= 1'b0;
      r_href_d1  <= 1'b0;
      r_data_d0  <= 8'h00;
    end else begin
      r_vsync_d0 <= cam_vsync;
      r_vsync_d1 <= r_vsync_d0;
      r_href_d0  <= cam_href;
      r_href_d1  <= r_href_d0;
      r_data_d0  <= cam_data;
    end
  end

  // Next value of the saturating frame wait counter
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (!sys_init_done) begin
      w_wait_next = 4'd0;
    end else if (w_pos_vsync && (r_wait_cnt < c_wait)) begin
      w_wait_next = r_wait_cnt + 4'd1;
    end
  end

  // Frame wait counter, capture enable and frame-start pulse
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      frame_val  <= 1'b0;
      wr_load    <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      frame_val  <= (w_wait_next == c_wait);
      // Compared against the pre-update count so the first pulse lands on
      // the vsync that also enables capture.
      wr_load    <= sys_init_done & w_pos_vsync & (r_wait_cnt >= c_wait_m1);
    end
  end

  // Byte toggle: high byte on even phase, complete word on odd phase.
  // A trailing odd byte sits in r_hi_byte and is simply never used.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_toggle    <= 1'b0;
      r_hi_byte   <= 8'h00;
      r_pend_word <= 16'h0000;
      r_pend_vld  <= 1'b0;
    end else begin
      r_pend_vld <= 1'b0;
      if (!r_href_d0) begin
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (!r_toggle) begin
          r_hi_byte <= r_data_d0;
        end else begin
          r_pend_word <= {r_hi_byte, r_data_d0};
          r_pend_vld  <= 1'b1;
        end
      end
    end
  end

  // Output word register; datain holds its value between strobes
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      datain_valid <= 1'b0;
      datain       <= 16'h0000;
    end else begin
      datain_valid <= w_word_strobe;
      if (w_word_strobe) begin
        datain <= r_pend_word;
      end
    end
  end

  // The last word of a line is still in flight when neg_href is seen, so
  // the line check uses the count including the strobe being issued now.
  always_comb begin
    w_word_total = r_word_cnt;
    if (w_word_strobe && (r_word_cnt != c_word_max)) begin
      w_word_total = r_word_cnt + 12'd1;
    end
  end

  // Word counter per line and line length check
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= 12'd0;
      line_err   <= 1'b0;
    end else begin
      line_err <= 1'b0;
      if (w_neg_href) begin
        r_word_cnt <= 12'd0;
        line_err   <= frame_val & sys_init_done & (w_word_total != c_h_pixel);
      end else begin
        r_word_cnt <= w_word_total;
      end
    end
  end

  // Line counter per frame and frame height check. On the vsync that
  // enables capture frame_val is still low, so the partial frame that
  // preceded it is never judged.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_line_cnt <= 11'd0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (w_pos_vsync) begin
        r_line_cnt <= 11'd0;
        frame_err  <= frame_val & sys_init_done & (r_line_cnt != c_v_pixel);
      end else if (w_neg_href && (r_line_cnt != c_line_max)) begin
        r_line_cnt <= r_line_cnt + 11'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_frame_packer
// Purpose  : Scoreboard bench for cmos_frame_packer with small frame geometry.
//            Expected events come from a frame/line level model; a negedge
//            monitor pops and compares every DUT output event.
// Revision : 1.0  initial release
// ============================================================================
module tb_cmos_frame_packer;

  localparam int WAIT = 3;
  localparam int HP   = 8;
  localparam int VP   = 4;

  localparam int K_WR   = 1;
  localparam int K_FERR = 2;
  localparam int K_WORD = 3;
  localparam int K_LERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        wr_load;
  logic        datain_valid;
  logic [15:0] datain;
  logic        frame_val;
  logic        line_err;
  logic        frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [19:0] exp_q[$];
  bit          sb_on = 1'b0;
  int          model_vcnt = 0;
  int          model_lines = 0;

  cmos_frame_packer #(
    .WAIT_FRAME (WAIT),
    .H_PIXEL    (HP),
    .V_PIXEL    (VP)
  ) dut (
    .cam_pclk      (clk),
    .rst           (rst),
    .sys_init_done (init),
    .cam_vsync     (vsync),
    .cam_href      (href),
    .cam_data      (data),
    .wr_load       (wr_load),
    .datain_valid  (datain_valid),
    .datain        (datain),
    .frame_val     (frame_val),
    .line_err      (line_err),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pop_cmp(input int kind, input logic [15:0] d, input string name);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected event data %h expected no event", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, {12'd0, 4'(kind), d}, {12'd0, e});
    end
  endtask

  // Monitor: fixed intra-cycle order matches the order the model pushes in
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (frame_err)    pop_cmp(K_FERR, 16'h0, "frame_err");
      if (wr_load)      pop_cmp(K_WR, 16'h0, "wr_load");
      if (datain_valid) pop_cmp(K_WORD, datain, "word");
      if (line_err)     pop_cmp(K_LERR, 16'h0, "line_err");
    end
  end

  // Frame boundary: model decides frame_err / wr_load, then vsync is driven
  task automatic do_vsync();
    int pre;
    pre = model_vcnt;
    if (pre >= WAIT && model_lines != VP) exp_q.push_back({4'(K_FERR), 16'h0});
    if (pre >= WAIT - 1) exp_q.push_back({4'(K_WR), 16'h0});
    if (pre < WAIT) model_vcnt = pre + 1;
    model_lines = 0;
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    repeat (5) @(negedge clk);
    check("frame_val", {31'd0, frame_val}, {31'd0, model_vcnt == WAIT});
  endtask

  // One line of random bytes; optional directed F8/1F latency probe
  task automatic do_line(input int nbytes, input bit lat);
    logic [7:0] b[$];
    for (int k = 0; k < nbytes; k++) b.push_back(8'($urandom));
    if (lat) begin
      b[0] = 8'hF8;
      b[1] = 8'h1F;
    end
    if (model_vcnt == WAIT) begin
      for (int k = 0; k + 1 < nbytes; k += 2) exp_q.push_back({4'(K_WORD), b[k], b[k+1]});
      if (nbytes / 2 != HP) exp_q.push_back({4'(K_LERR), 16'h0});
    end
    model_lines++;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (lat && (i == 2 || i == 3)) check("lat_early", {31'd0, datain_valid}, 32'd0);
      if (lat && i == 4) begin
        check("lat_valid", {31'd0, datain_valid}, 32'd1);
        check("lat_data", {16'd0, datain}, 32'h0000F81F);
      end
      href = 1'b1;
      data = b[i];
    end
    @(negedge clk);
    href = 1'b0;
    data = 8'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_load"}, {31'd0, wr_load}, 32'd0);
    check({tag, "_datain_valid"}, {31'd0, datain_valid}, 32'd0);
    check({tag, "_datain"}, {16'd0, datain}, 32'd0);
    check({tag, "_frame_val"}, {31'd0, frame_val}, 32'd0);
    check({tag, "_line_err"}, {31'd0, line_err}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  task automatic resync_model();
    model_vcnt = 0;
    model_lines = 0;
    exp_q.delete();
    sb_on = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    init = 1'b1;
    sb_on = 1'b1;

    // Skipped frames, then the enabling frame with the latency probe
    for (int f = 0; f < WAIT - 1; f++) begin
      do_vsync();
      do_line(2 * HP, 1'b0);
      do_line(2 * HP, 1'b0);
    end
    do_vsync();
    do_line(2 * HP, 1'b1);
    for (int l = 1; l < VP; l++) do_line(2 * HP, 1'b0);

    // Odd-length line: trailing byte dropped, line_err
    do_vsync();
    do_line(2 * HP - 1, 1'b0);
    for (int l = 1; l < VP; l++) do_line(2 * HP, 1'b0);

    // Short frame, then a frame of random line lengths
    do_vsync();
    for (int l = 0; l < VP - 1; l++) do_line(2 * HP, 1'b0);
    do_vsync();
    for (int l = 0; l < VP; l++) do_line(int'($urandom_range(12, 18)), 1'b0);
    do_vsync();

    // sys_init_done dropped mid-line
    check("q_empty_before_drop", exp_q.size(), 32'd0);
    sb_on = 1'b0;
    for (int i = 0; i < 2 * HP; i++) begin
      @(negedge clk);
      if (i == 7) begin
        check("drop_valid", {31'd0, datain_valid}, 32'd0);
        check("drop_frame_val", {31'd0, frame_val}, 32'd0);
      end
      if (i > 7 && i < 11) check("drop_valid_hold", {31'd0, datain_valid}, 32'd0);
      if (i == 6) init = 1'b0;
      href = 1'b1;
      data = 8'($urandom);
    end
    @(negedge clk) href = 1'b0;
    repeat (6) @(negedge clk);
    init = 1'b1;
    resync_model();
    for (int f = 0; f < WAIT; f++) begin
      do_vsync();
      do_line(2 * HP, 1'b0);
    end

    // Asynchronous reset mid-line
    check("q_empty_before_rst", exp_q.size(), 32'd0);
    check("fv_before_rst", {31'd0, frame_val}, 32'd1);
    sb_on = 1'b0;
    for (int i = 0; i < 2 * HP; i++) begin
      @(negedge clk);
      if (i == 8) begin
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
      end
      if (i == 11) rst = 1'b0;
      href = 1'b1;
      data = 8'($urandom);
    end
    @(negedge clk) href = 1'b0;
    repeat (6) @(negedge clk);
    resync_model();
    for (int f = 0; f < WAIT; f++) begin
      do_vsync();
      for (int l = 0; l < VP; l++) do_line(2 * HP, 1'b0);
    end
    do_vsync();

    repeat (10) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
